node_mem: RTL and testbench

- Byte-organised node-state memory: 2048 × 8 bits, accessed as 16-bit words.
- Sits on the far side of the routing core's memory bus and services the core's `address` / `wr_en` / `mem_data_in` requests, returning `mem_data_out`.
- After reset it zero-fills the whole array.
- It also offers a handshaked host port, used by the packet/config loader, which is arbitrated against core activity.

---
 rtl/node_mem_pkg.sv | 26 ++
 rtl/byte_ram_2bank.sv | 22 ++
 rtl/node_mem.sv | 72 +++++++
 tb/tb_node_mem.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/node_mem_pkg.sv
// node_mem_pkg: geometry, region map and FSM state type for the node-state memory
package node_mem_pkg;
    localparam int MEM_DEPTH   = 2048;
    localparam int MEM_WIDTH   = 8;
    localparam int WORD_WIDTH  = 16;
    localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH);
    localparam int WORDS       = MEM_DEPTH * MEM_WIDTH / WORD_WIDTH;
    localparam int WADDR_WIDTH = $clog2(WORDS);

    localparam logic [ADDR_WIDTH-1:0] FLAGS          = 11'h000;
    localparam logic [ADDR_WIDTH-1:0] KNOWN_SINKS    = 11'h008;
    localparam logic [ADDR_WIDTH-1:0] WORST_HOPS     = 11'h028;
    localparam logic [ADDR_WIDTH-1:0] NEIGHBOR_ID    = 11'h048;
    localparam logic [ADDR_WIDTH-1:0] CLUSTER_ID     = 11'h0C8;
    localparam logic [ADDR_WIDTH-1:0] BATTERY        = 11'h148;
    localparam logic [ADDR_WIDTH-1:0] QVALUE         = 11'h1C8;
    localparam logic [ADDR_WIDTH-1:0] SINK_IDS       = 11'h248;
    localparam logic [ADDR_WIDTH-1:0] HCM            = 11'h648;
    localparam logic [ADDR_WIDTH-1:0] BETTER_NBRS    = 11'h668;
    localparam logic [ADDR_WIDTH-1:0] KNOWN_SINK_CNT = 11'h688;
    localparam logic [ADDR_WIDTH-1:0] NEIGHBOR_CNT   = 11'h68A;
    localparam logic [ADDR_WIDTH-1:0] BETTER_CNT     = 11'h68C;
    localparam logic [ADDR_WIDTH-1:0] SINKID_CNT     = 11'h68E;

    typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/byte_ram_2bank.sv
// byte_ram_2bank: hi/lo byte banks forming 16-bit words, read-first registered read
module byte_ram_2bank
    import node_mem_pkg::*;
(
    input  logic                   clock,
    input  logic [WADDR_WIDTH-1:0] addr,
    input  logic                   we,
    input  logic [WORD_WIDTH-1:0]  wdata,
    output logic [WORD_WIDTH-1:0]  rdata
);
    logic [MEM_WIDTH-1:0] bank_hi [WORDS];
    logic [MEM_WIDTH-1:0] bank_lo [WORDS];

    // even byte in the high half, odd byte in the low half; read returns pre-write data
    always_ff @(posedge clock) begin
        if (we) begin
            bank_hi[addr] <= wdata[WORD_WIDTH-1:MEM_WIDTH];
            bank_lo[addr] <= wdata[MEM_WIDTH-1:0];
        end
        rdata <= {bank_hi[addr], bank_lo[addr]};
    end
endmodule

// File: rtl/node_mem.sv
// node_mem: node-state memory with self-clear sequence, core port and arbitrated host port
module node_mem
    import node_mem_pkg::*;
(
    input  logic                  clock,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  wr_en,
    input  logic [WORD_WIDTH-1:0] mem_data_in,
    output logic [WORD_WIDTH-1:0] mem_data_out,
    input  logic                  core_active,
    input  logic                  init_start,
    output logic                  ready,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [WORD_WIDTH-1:0] host_wdata,
    output logic [WORD_WIDTH-1:0] host_rdata,
    output logic                  host_ack
);
    state_t                 state, next_state;
    logic [WADDR_WIDTH-1:0] clr_cnt;
    logic                   core_vld;
    logic                   svc;
    logic [WADDR_WIDTH-1:0] ram_addr;
    logic                   ram_we;
    logic [WORD_WIDTH-1:0]  ram_wdata;
    logic [WORD_WIDTH-1:0]  ram_rdata;
    logic                   unused_bits;

    assign unused_bits = address[0] ^ host_addr[0];

    // state, clear counter and the flags that qualify the shared read register
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            core_vld <= 1'b0;
            host_ack <= 1'b0;
        end else begin
            state    <= next_state;
            clr_cnt  <= (state == CLEAR && !init_start) ? clr_cnt + 1'b1 : '0;
            core_vld <= ready && !svc;
            host_ack <= svc;
        end
    end

    // init_start always restarts the clear; the last cleared word hands over to READY
    always_comb begin
        next_state = init_start ? CLEAR
                   : (state == CLEAR && clr_cnt == WADDR_WIDTH'(WORDS - 1)) ? READY : state;
    end

    // port muxing: clear owns the RAM, else an eligible host request, else the core
    always_comb begin
        ready        = state == READY;
        svc          = ready && !core_active && host_req && !host_ack;
        ram_addr     = !ready ? clr_cnt : svc ? host_addr[ADDR_WIDTH-1:1] : address[ADDR_WIDTH-1:1];
        ram_we       = !ready || (svc ? host_we : wr_en);
        ram_wdata    = !ready ? '0 : svc ? host_wdata : mem_data_in;
        mem_data_out = core_vld ? ram_rdata : '0;
        host_rdata   = host_ack ? ram_rdata : '0;
    end

    byte_ram_2bank u_ram (
        .clock (clock),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_node_mem.sv
// tb_node_mem: table, hand sequences and random traffic against a word-array model
module tb_node_mem;
    logic        clock, nrst;
    logic [10:0] address, host_addr;
    logic        wr_en, core_active, init_start, ready, host_req, host_we, host_ack;
    logic [15:0] mem_data_in, mem_data_out, host_wdata, host_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mdl [1024];
    logic [15:0] last_rdata;

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [10];

    node_mem dut (
        .clock        (clock),
        .nrst         (nrst),
        .address      (address),
        .wr_en        (wr_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .core_active  (core_active),
        .init_start   (init_start),
        .ready        (ready),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .host_ack     (host_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic zero_model();
        for (int i = 0; i < 1024; i++) mdl[i] = 16'h0000;
    endtask

    task automatic idle();
        address = '0; wr_en = 0; mem_data_in = '0; core_active = 0; init_start = 0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    endtask

    // ready is low for the first 1023 edges of a clear and high from the 1024th
    task automatic run_clear(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check("clear_ready", 16'(ready), 16'(k >= 1023));
            check("clear_dout", mem_data_out, 16'h0000);
        end
    endtask

    task automatic core_op(input logic we, input logic [10:0] a, input logic [15:0] d,
                           input logic [15:0] exp, input string name);
        address = a; wr_en = we; mem_data_in = d;
        tick();
        check(name, mem_data_out, exp);
        if (we) mdl[a[10:1]] = d;
        wr_en = 0;
    endtask

    // core held busy for 'busy' cycles, then released; ack is due the next cycle
    task automatic host_op(input logic we, input logic [10:0] a, input logic [15:0] d, input int busy);
        host_req = 1; host_we = we; host_addr = a; host_wdata = d; wr_en = 0;
        core_active = busy > 0;
        for (int i = 0; i < busy; i++) begin
            tick();
            check("host_busy_noack", 16'(host_ack), 16'h0000);
        end
        core_active = 0;
        tick();
        check("host_ack", 16'(host_ack), 16'h0001);
        last_rdata = host_rdata;
        if (!we) check("host_rdata", host_rdata, mdl[a[10:1]]);
        else mdl[a[10:1]] = d;
        host_req = 0; host_we = 0;
        tick();
        check("host_ack_drop", 16'(host_ack), 16'h0000);
    endtask

    function automatic logic [10:0] rnd_addr();
        logic [10:0] r = 11'($urandom);
        return ($urandom_range(0, 1) == 1) ? {6'h0E, r[4:0]} : r;
    endfunction

    initial begin
        tbl[0] = '{1'b1, 11'h148, 16'hA55A, 16'h0000};
        tbl[1] = '{1'b0, 11'h148, 16'h0000, 16'hA55A};
        tbl[2] = '{1'b0, 11'h149, 16'h0000, 16'hA55A};
        tbl[3] = '{1'b1, 11'h1C8, 16'h0003, 16'h0000};
        tbl[4] = '{1'b1, 11'h1C8, 16'h0007, 16'h0003};
        tbl[5] = '{1'b0, 11'h1C8, 16'h0000, 16'h0007};
        tbl[6] = '{1'b1, 11'h689, 16'hBEEF, 16'h0000};
        tbl[7] = '{1'b0, 11'h688, 16'h0000, 16'hBEEF};
        tbl[8] = '{1'b1, 11'h7FF, 16'h1357, 16'h0000};
        tbl[9] = '{1'b0, 11'h7FE, 16'h0000, 16'h1357};

        idle();
        zero_model();
        nrst = 1;
        #1 nrst = 0;
        repeat (3) tick();
        check("rst_ready", 16'(ready), 16'h0000);
        check("rst_dout", mem_data_out, 16'h0000);
        check("rst_hrdata", host_rdata, 16'h0000);
        check("rst_hack", 16'(host_ack), 16'h0000);
        nrst = 1;
        run_clear(1030);
        core_op(0, 11'h68A, 0, 16'h0000, "zero_68a");
        core_op(0, 11'h7FE, 0, 16'h0000, "zero_7fe");

        for (int i = 0; i < 10; i++)
            core_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("tbl%0d", i));

        host_op(0, 11'h148, '0, 0);
        check("host_hi_byte", {8'h00, last_rdata[15:8]}, 16'h00A5);
        check("host_lo_byte", {8'h00, last_rdata[7:0]}, 16'h005A);
        host_op(0, 11'h149, '0, 0);

        host_op(1, 11'h688, 16'h1234, 5);
        core_op(0, 11'h688, 0, 16'h1234, "core_after_host");

        // held request: acks in cycles n+1 and n+3
        host_req = 1; host_we = 0; host_addr = 11'h1C8;
        tick(); check("b2b_ack1", 16'(host_ack), 16'h0001);
        check("b2b_rdata", host_rdata, 16'h0007);
        tick(); check("b2b_gap", 16'(host_ack), 16'h0000);
        tick(); check("b2b_ack2", 16'(host_ack), 16'h0001);
        host_req = 0;
        tick(); check("b2b_drop", 16'(host_ack), 16'h0000);

        for (int i = 0; i < 240; i++) begin
            if (i % 24 == 23) host_op(1'($urandom_range(0, 1)), rnd_addr(), 16'($urandom), $urandom_range(0, 3));
            else begin
                logic [10:0] a = rnd_addr();
                core_active = 1'($urandom_range(0, 1));
                core_op(1'($urandom_range(0, 1)), a, 16'($urandom), mdl[a[10:1]], "rand_core");
            end
        end
        idle();
        tick();

        // re-clear with a pending host read and a core write that must be dropped
        init_start = 1;
        tick();
        init_start = 0;
        check("init_ready", 16'(ready), 16'h0000);
        for (int k = 0; k <= 1024; k++) begin
            if (k == 100) begin host_req = 1; host_we = 0; host_addr = 11'h148; end
            if (k == 200) begin wr_en = 1; address = 11'h010; mem_data_in = 16'hFFFF; end
            if (k == 201) wr_en = 0;
            tick();
            check("init_ready_t", 16'(ready), 16'(k >= 1023));
            check("init_hack", 16'(host_ack), 16'(k == 1024));
            check("init_dout", mem_data_out, 16'h0000);
        end
        check("init_hrdata", host_rdata, 16'h0000);
        idle();
        tick();
        zero_model();
        for (int w = 0; w < 1024; w++) core_op(0, {10'(w), 1'b0}, 0, 16'h0000, "init_zero");

        core_op(1, 11'h148, 16'hA55A, mdl[11'h148 >> 1], "pre_rst_wr");
        core_op(0, 11'h148, 0, 16'hA55A, "pre_rst_rd");
        #2 nrst = 0;
        #1 check("arst_dout", mem_data_out, 16'h0000);
        check("arst_ready", 16'(ready), 16'h0000);
        #1 nrst = 1;
        host_req = 1; host_we = 0; host_addr = 11'h148;
        for (int k = 0; k < 500; k++) begin
            tick();
            check("clr500_hack", 16'(host_ack), 16'h0000);
        end
        #2 nrst = 0;
        #1 check("mid_dout", mem_data_out, 16'h0000);
        check("mid_hrdata", host_rdata, 16'h0000);
        check("mid_hack", 16'(host_ack), 16'h0000);
        check("mid_ready", 16'(ready), 16'h0000);
        host_req = 0;
        #1 nrst = 1;
        zero_model();
        run_clear(1030);
        host_op(0, 11'h148, '0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
